seq_sched: RTL and testbench

SEQ_SCHED -- requirements
Module: seq_sched

---
 rtl/seq_sched.sv | 128 ++++++++++++
 tb/tb_seq_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_sched.sv
// Four-requester frame scheduler: serialises the granted requester's byte MSB first
// into a shared sequence detector and counts its hits. Define SEQ_SCHED_FIXED_PRI_EN
// for fixed priority (lowest index wins); otherwise arbitration is round-robin.
module seq_sched (
  input  logic        Clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  input  logic        det_hit,
  output logic        det_in,
  output logic        det_clr,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        done,
  output logic [1:0]  gnt_id,
  output logic [3:0]  hit_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  word;
  logic [2:0]  idx;
  logic [1:0]  winner;

`ifdef SEQ_SCHED_FIXED_PRI_EN
  // Descending scan so the lowest requesting index is the final assignment.
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`else
  logic [1:0] ptr;

  // Search starts at ptr; descending offsets leave the nearest requester as winner.
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      ptr <= 2'd0;
    end else if (state == DONE) begin
      ptr <= gnt_id + 2'd1;
    end
  end
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    det_clr    = 1'b0;
    det_in     = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    gnt        = 4'b0001 << gnt_id;
    ack        = 4'b0000;
    case (state)
      IDLE: begin
        busy = 1'b0;
        gnt  = 4'b0000;
        if (req != 4'b0000) state_next = CLR;
      end
      CLR: begin
        det_clr    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        det_in = word[idx];
        if (idx == 3'd0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        ack        = 4'b0001 << gnt_id;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        gnt        = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  // gnt_id/word latch on acceptance; hit_cnt persists until the following CLR.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      word    <= 8'd0;
      idx     <= 3'd0;
      gnt_id  <= 2'd0;
      hit_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            gnt_id <= winner;
            word   <= data_in[{winner, 3'b000} +: 8];
          end
        end
        CLR: begin
          hit_cnt <= 4'd0;
          idx     <= 3'd7;
        end
        SHIFT: begin
          if (det_hit && (hit_cnt != 4'hF)) hit_cnt <= hit_cnt + 4'd1;
          idx <= idx - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sched.sv
// Randomised and directed bench for seq_sched with an overlapping Mealy "1011"
// detector model; expected grants and hit counts come from a behavioural model.
module tb_seq_sched;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data_in = 32'd0;
  logic        det_hit;
  logic        det_in;
  logic        det_clr;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        done;
  logic [1:0]  gnt_id;
  logic [3:0]  hit_cnt;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  model_ptr = 2'd0;
  logic [1:0]  det_len;

  seq_sched dut (
    .Clk     (Clk),
    .reset   (reset),
    .req     (req),
    .data_in (data_in),
    .det_hit (det_hit),
    .det_in  (det_in),
    .det_clr (det_clr),
    .gnt     (gnt),
    .ack     (ack),
    .done    (done),
    .gnt_id  (gnt_id),
    .hit_cnt (hit_cnt),
    .busy    (busy)
  );

  always #5 Clk = ~Clk;

  // External detector: det_len is the length of the "1011" prefix matched so far.
  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      det_len <= 2'd0;
    end else if (det_clr) begin
      det_len <= 2'd0;
    end else begin
      case (det_len)
        2'd0: det_len <= det_in ? 2'd1 : 2'd0;
        2'd1: det_len <= det_in ? 2'd1 : 2'd2;
        2'd2: det_len <= det_in ? 2'd3 : 2'd0;
        default: det_len <= det_in ? 2'd1 : 2'd2;
      endcase
    end
  end

  assign det_hit = (det_len == 2'd3) && det_in;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int count_pattern(input logic [7:0] w);
    int n;
    n = 0;
    for (int i = 7; i >= 3; i--) begin
      if (w[i -: 4] == 4'b1011) n++;
    end
    return n;
  endfunction

  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    int j;
    for (int i = 0; i < 4; i++) begin
`ifdef SEQ_SCHED_FIXED_PRI_EN
      j = i;
`else
      j = (int'(p) + i) % 4;
`endif
      if (r[j]) return 2'(j);
    end
    return 2'd0;
  endfunction

  // Runs one frame from an IDLE negedge; at cycle change_cycle req becomes new_req.
  task automatic run_frame(input int change_cycle, input logic [3:0] new_req);
    int         waited;
    int         cyc;
    bit         seen_done;
    logic [1:0] exp_id;
    logic [7:0] exp_word;
    int         exp_hits;
    waited = 0;
    while (busy && waited < 30) begin
      @(negedge Clk);
      waited++;
    end
    check_output("idle_before_frame", {31'd0, busy}, 32'd0);
    exp_id   = pick_winner(req, model_ptr);
    exp_word = data_in[{exp_id, 3'b000} +: 8];
    exp_hits = count_pattern(exp_word);
    seen_done = 1'b0;
    cyc = 0;
    while (!seen_done && cyc < 12) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        check_output("clr_pulse", {31'd0, det_clr}, 32'd1);
        check_output("gnt_in_clr", {28'd0, gnt}, 32'd1 << exp_id);
      end else if (cyc <= 9) begin
        check_output("det_in_bit", {31'd0, det_in}, {31'd0, exp_word[9 - cyc]});
        check_output("clr_in_shift", {31'd0, det_clr}, 32'd0);
      end
      if (done) seen_done = 1'b1;
      if (cyc == change_cycle) req = new_req;
    end
    check_output("done_latency", cyc, 10);
    check_output("done_gnt_id", {30'd0, gnt_id}, {30'd0, exp_id});
    check_output("done_hit_cnt", {28'd0, hit_cnt}, exp_hits);
    check_output("done_ack", {28'd0, ack}, 32'd1 << exp_id);
    check_output("done_gnt", {28'd0, gnt}, 32'd1 << exp_id);
`ifndef SEQ_SCHED_FIXED_PRI_EN
    model_ptr = exp_id + 2'd1;
`endif
    @(negedge Clk);
    check_output("after_done_pulses", {23'd0, busy, done, ack, gnt}, 32'd0);
    check_output("retain_id_hits", {26'd0, gnt_id, hit_cnt}, {26'd0, exp_id, 4'(exp_hits)});
  endtask

  task automatic apply_reset_pulse();
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    model_ptr = 2'd0;
  endtask

  initial begin
    logic [1:0] exp_seq [5];
    logic [3:0] r;
`ifdef SEQ_SCHED_FIXED_PRI_EN
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    #2 reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_output("in_reset_outputs", {17'd0, busy, det_clr, det_in, done, gnt, ack, gnt_id, hit_cnt}, 32'd0);
    reset = 1'b1;
    model_ptr = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check_output("idle_outputs", {17'd0, busy, det_clr, det_in, done, gnt, ack, gnt_id, hit_cnt}, 32'd0);
    end

    req = 4'b0010;
    data_in = 32'h0000_B600;
    run_frame(10, 4'b0000);
    check_output("directed_hit_cnt", {28'd0, hit_cnt}, 32'd2);
    check_output("directed_gnt_id", {30'd0, gnt_id}, 32'd1);

    apply_reset_pulse();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      data_in = $urandom;
      run_frame(0, 4'b0000);
      check_output("arb_sequence", {30'd0, gnt_id}, {30'd0, exp_seq[i]});
    end

    req = 4'b1000;
    data_in = 32'h0000_0000;
    run_frame(0, 4'b0000);
    check_output("zero_byte_hits", {28'd0, hit_cnt}, 32'd0);
    check_output("zero_byte_id", {30'd0, gnt_id}, 32'd3);
    data_in = 32'hFF00_0000;
    run_frame(0, 4'b0000);
    check_output("ones_byte_hits", {28'd0, hit_cnt}, 32'd0);
    req = 4'b0000;
    @(negedge Clk);

    req = 4'b0100;
    data_in = 32'h00B6_0000;
    repeat (5) @(negedge Clk);
    reset = 1'b0;
    #1;
    check_output("abort_outputs", {17'd0, busy, det_clr, det_in, done, gnt, ack, gnt_id, hit_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check_output("abort_no_done", {27'd0, done, ack}, 32'd0);
    end
    reset = 1'b1;
    model_ptr = 2'd0;
    run_frame(0, 4'b0000);
    req = 4'b0000;
    @(negedge Clk);

    req = 4'b0001;
    data_in = 32'h0000_00DB;
    run_frame(4, 4'b0000);

    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom_range(1, 15));
      req = r;
      data_in = $urandom;
      run_frame($urandom_range(1, 12), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
